uart_program_loader: RTL

// - CPU-side end of the boot link: announces readiness with 0x99, receives program size + program bytes over

---
 rtl/loader_pkg.sv | 23 ++
 rtl/uart_byte_sender.sv | 32 +++
 rtl/uart_program_loader.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// The size header is enabled by defining LOADER_SIZE_HDR_EN.
package loader_pkg;

    typedef enum logic [2:0] {
        SEND_SYNC,
        RECV_SIZE,
        RECV_DATA,
        WAIT_TX,
        SEND_DONE,
        DONE,
        ERROR
    } loader_state_t;

    localparam logic [7:0] SYNC_READY = 8'h99;
    localparam logic [7:0] SYNC_DONE  = 8'hAA;
    localparam int         WORD_BYTES = 4;

    function automatic logic [31:0] capacity_bytes(input int addr_w);
        return 32'(WORD_BYTES) << addr_w;
    endfunction

endpackage

// File: rtl/uart_byte_sender.sv
// Request/ack wrapper around UART_TX: one tx_start pulse per accepted
// request, followed by a guard cycle before tx_busy is honoured again.
module uart_byte_sender (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req,
    input  logic [7:0] data,
    input  logic       tx_busy,
    output logic       ack,
    output logic       idle,
    output logic [7:0] tx_sdata,
    output logic       tx_start
);

    logic guard;

    assign ack  = req & ~tx_busy & ~tx_start & ~guard;
    assign idle = ~tx_start & ~guard;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_start <= 1'b0;
            tx_sdata <= 8'd0;
            guard    <= 1'b0;
        end else begin
            tx_start <= ack;
            guard    <= tx_start;
            if (ack) tx_sdata <= data;
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Boot-link loader: sends 0x99, streams program bytes into imem, sends 0xAA.
// Define LOADER_SIZE_HDR_EN to expect a 4-byte little-endian size header.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int IMEM_ADDR_W = 14,
    parameter int PROG_BYTES  = 128
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             rx_rdata,
    input  logic                   rx_rdata_ready,
    input  logic                   rx_ferr,
    output logic [7:0]             tx_sdata,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [31:0]            imem_wdata,
    output logic                   load_done,
    output logic                   load_err
);

    loader_state_t state, state_next;

    logic [31:0] cnt;
    logic [31:0] size;
    logic [31:0] wbuf;
    logic [31:0] word_next;
    logic [1:0]  lane;
    logic        take;
    logic        bad;
    logic        last;
    logic        req;
    logic        ack;
    logic        idle;
    logic        sent;
    logic [7:0]  req_data;

    assign take = rx_rdata_ready & ~rx_ferr;
    assign bad  = rx_rdata_ready & rx_ferr;
    assign lane = cnt[1:0];
    assign last = (cnt == size - 32'd1);

    // Lane 0 starts a fresh word so unfilled upper lanes read as zero.
    assign word_next = (lane == 2'd0) ? {24'd0, rx_rdata}
                     : wbuf | ({24'd0, rx_rdata} << {lane, 3'b000});

`ifdef LOADER_SIZE_HDR_EN
    localparam logic [31:0] CAPACITY = capacity_bytes(IMEM_ADDR_W);

    logic [31:0] size_next;

    assign size_next = {rx_rdata, size[31:8]};

    always_ff @(posedge clk) begin
        if (!reset_n) size <= 32'd0;
        else if (state == RECV_SIZE && take) size <= size_next;
    end
`else
    assign size = 32'(PROG_BYTES);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) state <= SEND_SYNC;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        req        = 1'b0;
        req_data   = SYNC_READY;
        unique case (state)
            SEND_SYNC: begin
                req = 1'b1;
                if (ack) begin
`ifdef LOADER_SIZE_HDR_EN
                    state_next = RECV_SIZE;
`else
                    state_next = RECV_DATA;
`endif
                end
            end
            RECV_SIZE: begin
`ifdef LOADER_SIZE_HDR_EN
                if (bad) begin
                    state_next = ERROR;
                end else if (take && lane == 2'd3) begin
                    if (size_next == 32'd0) state_next = SEND_DONE;
                    else if (size_next > CAPACITY) state_next = ERROR;
                    else state_next = RECV_DATA;
                end
`endif
            end
            RECV_DATA: begin
                if (bad) state_next = ERROR;
                else if (take && last) state_next = WAIT_TX;
            end
            WAIT_TX: begin
                if (!tx_busy) state_next = SEND_DONE;
            end
            SEND_DONE: begin
                req      = ~sent;
                req_data = SYNC_DONE;
                if (sent && idle) state_next = DONE;
            end
            DONE:    state_next = DONE;
            ERROR:   state_next = ERROR;
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt        <= 32'd0;
            wbuf       <= 32'd0;
            sent       <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            if (state == SEND_DONE && ack) sent <= 1'b1;
            if (state == RECV_SIZE && take) begin
                cnt <= (lane == 2'd3) ? 32'd0 : cnt + 32'd1;
            end
            if (state == RECV_DATA && take) begin
                cnt  <= cnt + 32'd1;
                wbuf <= word_next;
                if (lane == 2'd3 || last) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= cnt[IMEM_ADDR_W+1:2];
                    imem_wdata <= word_next;
                end
            end
        end
    end

    assign load_done = (state == DONE);
    assign load_err  = (state == ERROR);

    uart_byte_sender u_sender (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .data     (req_data),
        .tx_busy  (tx_busy),
        .ack      (ack),
        .idle     (idle),
        .tx_sdata (tx_sdata),
        .tx_start (tx_start)
    );

endmodule
